// File: rtl/btn_debounce_array.sv
// btn_debounce_array: 2-FF synchronised, 1 ms-tick debounced button array with press/release pulses.
// Define BTN_AUTOREPEAT_EN to add per-channel auto-repeat press pulses while a button stays held.
module btn_debounce_array #(
    parameter int N_CH            = 4,
    parameter int CLK_FREQ        = 25,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released,
    output logic            any_pressed
);
    localparam int TICK_CYC = CLK_FREQ * 1000;
    localparam int PW = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;
    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    logic [PW-1:0]   presc;
    logic            tick;
    logic [N_CH-1:0] s1, s, diff, done, rise, level_nxt, press_nxt;
    logic [CW-1:0]   cnt [N_CH];
    logic [CW-1:0]   cnt_nxt [N_CH];
    assign tick = presc == PW'(TICK_CYC - 1);
    assign diff = s ^ level;
    assign level_nxt = level ^ done;
    assign rise = done & ~level;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc <= '0;
        else presc <= tick ? '0 : presc + 1'b1;
    end
    // any mismatch-free cycle clears the counter, so a glitch restarts qualification
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            done[i] = diff[i] && tick && cnt[i] == CW'(DEBOUNCE_MS - 1);
            cnt_nxt[i] = (!diff[i] || done[i]) ? '0 : cnt[i] + CW'(tick);
        end
    end
`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} rep_t;
    localparam int HMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int HW = $clog2(HMAX + 1);
    rep_t            st [N_CH];
    rep_t            st_nxt [N_CH];
    logic [HW-1:0]   hcnt [N_CH];
    logic [HW-1:0]   hcnt_nxt [N_CH];
    logic [N_CH-1:0] fall, rep;
    assign fall = done & level;
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                st[i]   <= IDLE;
                hcnt[i] <= '0;
            end else begin
                st[i]   <= st_nxt[i];
                hcnt[i] <= hcnt_nxt[i];
            end
        end
    end
    // a falling level always wins, so a repeat never lands on the release cycle
    always_comb begin
        rep = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_nxt[i] = st[i];
            hcnt_nxt[i] = hcnt[i];
            if (fall[i]) begin
                st_nxt[i] = IDLE;
                hcnt_nxt[i] = '0;
            end else if (st[i] == IDLE) begin
                st_nxt[i] = rise[i] ? HELD : IDLE;
                hcnt_nxt[i] = '0;
            end else if (tick) begin
                if (hcnt[i] == HW'((st[i] == HELD ? REPEAT_DELAY_MS : REPEAT_RATE_MS) - 1)) begin
                    rep[i] = 1'b1;
                    st_nxt[i] = REPEAT;
                    hcnt_nxt[i] = '0;
                end else begin
                    hcnt_nxt[i] = hcnt[i] + 1'b1;
                end
            end
        end
    end
    assign press_nxt = rise | rep;
`else
    assign press_nxt = rise;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            s           <= '0;
            level       <= '0;
            press       <= '0;
            released    <= '0;
            any_pressed <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            s1          <= btn_raw;
            s           <= s1;
            level       <= level_nxt;
            press       <= press_nxt;
            released    <= done & level;
            any_pressed <= |level_nxt;
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
        end
    end
endmodule

// File: tb/tb_btn_debounce_array.sv
// tb_btn_debounce_array: directed checks of debounce latency, pulses, glitch rejection and async reset.
module tb_btn_debounce_array;
`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD3 = 40000;
    localparam int NP3   = 5;
`else
    localparam int HOLD3 = 10000;
    localparam int NP3   = 1;
`endif
    logic       clk, rst, any_pressed;
    logic [1:0] btn_raw, level, press, released, pp;
    int cyc, n_cmp, n_bad, both, wide, lv1_seen, lat, p0, r0, p1, r1;
    int np [2];
    int nr [2];

    btn_debounce_array #(
        .N_CH(2), .CLK_FREQ(1), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .level(level), .press(press),
        .released(released), .any_pressed(any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (press[i]) np[i] <= np[i] + 1;
            if (released[i]) nr[i] <= nr[i] + 1;
            if (press[i] && released[i]) both <= both + 1;
            if (press[i] && pp[i]) wide <= wide + 1;
        end
        if (level[1]) lv1_seen <= lv1_seen + 1;
        pp <= press;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int ch, input logic v, output int l);
        int t0;
        t0 = cyc;
        l = -1;
        for (int k = 0; k < 4200; k++) begin
            @(negedge clk);
            if (level[ch] === v) begin
                l = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0; both = 0; wide = 0; lv1_seen = 0;
        np[0] = 0; np[1] = 0; nr[0] = 0; nr[1] = 0; pp = '0;
        rst = 1'b1;
        btn_raw = '0;
        step(3);
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", released, 0);
        chk("rst_any", any_pressed, 0);
        step(1);
        rst = 1'b0;
        step(5);
        // 1: clean press held 10 ms then released
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        chk("t1_rise_lat_3002_4002", lat >= 3002 && lat <= 4002, 1);
        chk("t1_press0_with_level", press[0], 1);
        chk("t1_any", any_pressed, 1);
        step(10000 - lat);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        chk("t1_fall_lat_3002_4002", lat >= 3002 && lat <= 4002, 1);
        chk("t1_release0_with_level", released[0], 1);
        step(3);
        chk("t1_press_count", np[0], 1);
        chk("t1_release_count", nr[0], 1);
        chk("t1_any_after", any_pressed, 0);
        // 2: 2 ms bursts on channel 1 never qualify
        p1 = np[1]; r1 = nr[1];
        for (int k = 0; k < 2; k++) begin
            btn_raw[1] = 1'b1;
            step(2000);
            btn_raw[1] = 1'b0;
            step(2000);
        end
        chk("t2_level1_seen", lv1_seen, 0);
        chk("t2_press1", np[1] - p1, 0);
        chk("t2_release1", nr[1] - r1, 0);
        // 3: long hold, auto-repeat count depends on build
        p0 = np[0]; r0 = nr[0];
        btn_raw[0] = 1'b1;
        step(HOLD3);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        chk("t3_fall_lat_3002_4002", lat >= 3002 && lat <= 4002, 1);
        step(3);
        chk("t3_press_count", np[0] - p0, NP3);
        chk("t3_release_count", nr[0] - r0, 1);
        // 4: simultaneous press on both channels
        btn_raw = 2'b11;
        wait_level(0, 1'b1, lat);
        chk("t4_press0", press[0], 1);
        chk("t4_press1", press[1], 1);
        chk("t4_level1", level[1], 1);
        chk("t4_any", any_pressed, 1);
        step(1);
        btn_raw = 2'b00;
        wait_level(0, 1'b0, lat);
        chk("t4_both_fall", level, 0);
        step(3);
        // 5: async reset mid-hold, button held through reset release
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        step(1000);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_level", level, 0);
        chk("t5_rst_any", any_pressed, 0);
        chk("t5_rst_pulses", {press, released}, 0);
        step(3);
        p0 = np[0];
        rst = 1'b0;
        wait_level(0, 1'b1, lat);
        chk("t5_repress_lat_3002_4002", lat >= 3002 && lat <= 4002, 1);
        step(2);
        chk("t5_repress_count", np[0] - p0, 1);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        step(3);
        // 6: single-cycle glitch while accepted high
        p0 = np[0]; r0 = nr[0];
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        step(1000);
        btn_raw[0] = 1'b0;
        step(1);
        btn_raw[0] = 1'b1;
        step(1000);
        chk("t6_level_held", level[0], 1);
        chk("t6_no_release", nr[0] - r0, 0);
        chk("t6_one_press", np[0] - p0, 1);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        step(3);
        chk("never_both", both, 0);
        chk("pulse_width", wide, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
